w5300_bus_arbiter: RTL and testbench



---
 rtl/w5300_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_w5300_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter sharing the W5300 register port between N requesters.
// Optional BUSY watchdog when W5300_ARB_TIMEOUT_EN is defined.
module w5300_bus_arbiter #(
   parameter int N              = 4,
   parameter int MAX_BURST      = 16,
   parameter int TIMEOUT_CYCLES = 6000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    lock,
   input  logic [N*11-1:0] req_addr,
   input  logic [N*16-1:0] req_wr_data,
   output logic [N-1:0]    grant,
   output logic [N-1:0]    done,
   output logic [15:0]     rd_data,
   output logic            if_req,
   output logic [10:0]     if_addr,
   output logic [15:0]     if_wr_data,
   input  logic [15:0]     if_rd_data,
   input  logic            if_op_state,
   output logic            err
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   if (N < 2 || N > 8 || MAX_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("w5300_bus_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {ARB, BUSY, DONE, HOLD} state_t;

   state_t        state;
   logic [LW-1:0] last;
   logic [LW-1:0] owner;
   logic [CW-1:0] burst_cnt;
   logic [LW-1:0] win;
   logic          win_ok;
   logic          hold_ok;
   logic          tmo_hit;

   // First requester after the last owner, wrapping modulo N
   always_comb begin
      win    = '0;
      win_ok = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (int'(last) + k) % N;
         if (!win_ok && req[LW'(j)]) begin
            win_ok = 1'b1;
            win    = LW'(j);
         end
      end
   end

   assign hold_ok = lock[owner] && req[owner] &&
                    (int'(burst_cnt) < MAX_BURST - 1);

`ifdef W5300_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_cnt;
   logic          err_q;

   assign tmo_hit = (int'(tmo_cnt) == TIMEOUT_CYCLES - 1);
   assign err     = err_q;

   // Counter is held at zero outside BUSY, so every BUSY entry starts fresh
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else if (state != BUSY || if_op_state) begin
         tmo_cnt <= '0;
      end else if (tmo_hit) begin
         tmo_cnt <= '0;
         err_q   <= 1'b1;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARB;
         grant      <= '0;
         done       <= '0;
         rd_data    <= '0;
         if_req     <= 1'b0;
         if_addr    <= '0;
         if_wr_data <= '0;
         last       <= LW'(N - 1);
         owner      <= '0;
         burst_cnt  <= '0;
      end else begin
         unique case (state)
            ARB: begin
               if (win_ok) begin
                  grant      <= N'(1) << win;
                  owner      <= win;
                  if_addr    <= req_addr[int'(win)*11 +: 11];
                  if_wr_data <= req_wr_data[int'(win)*16 +: 16];
                  if_req     <= 1'b1;
                  burst_cnt  <= '0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (if_op_state) begin
                  if_req  <= 1'b0;
                  rd_data <= if_rd_data;
                  done    <= grant;
                  state   <= DONE;
               end else if (tmo_hit) begin
                  if_req  <= 1'b0;
                  rd_data <= 16'hFFFF;
                  done    <= grant;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= '0;
               state <= HOLD;
            end
            HOLD: begin
               // Locked owner keeps the bus without passing through ARB
               if (hold_ok) begin
                  if_addr    <= req_addr[int'(owner)*11 +: 11];
                  if_wr_data <= req_wr_data[int'(owner)*16 +: 16];
                  burst_cnt  <= burst_cnt + CW'(1);
                  if_req     <= 1'b1;
                  state      <= BUSY;
               end else begin
                  grant <= '0;
                  last  <= owner;
                  state <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed bench for w5300_bus_arbiter; timeout case compiled
// only with W5300_ARB_TIMEOUT_EN.
module tb_w5300_bus_arbiter;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N*11-1:0] req_addr;
   logic [N*16-1:0] req_wr_data;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic [15:0]     rd_data;
   logic            if_req;
   logic [10:0]     if_addr;
   logic [15:0]     if_wr_data;
   logic [15:0]     if_rd_data;
   logic            if_op_state;
   logic            err;

   int total = 0;
   int bad   = 0;
   int n;

   w5300_bus_arbiter #(
      .N(N), .MAX_BURST(16), .TIMEOUT_CYCLES(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
      .req_addr(req_addr), .req_wr_data(req_wr_data),
      .grant(grant), .done(done), .rd_data(rd_data),
      .if_req(if_req), .if_addr(if_addr), .if_wr_data(if_wr_data),
      .if_rd_data(if_rd_data), .if_op_state(if_op_state), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bounded wait for the next transaction to appear on the interface
   task automatic wait_req(output int cnt);
      cnt = 0;
      while (!if_req && cnt < 20) begin
         tick();
         cnt++;
      end
   endtask

   task automatic complete(input logic [15:0] d);
      if_rd_data  = d;
      if_op_state = 1'b1;
      tick();
      if_op_state = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; lock = '0;
      req_addr = '0; req_wr_data = '0;
      if_rd_data = '0; if_op_state = 1'b0;
      tick(); tick();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_if_req", 32'(if_req), 32'h0);
      check("rst_rd_data", 32'(rd_data), 32'h0);
      check("rst_if_addr", 32'(if_addr), 32'h0);
      check("rst_err", 32'(err), 32'h0);

      // single read from requester 0, completion after 3 BUSY cycles
      rst_n = 1'b1;
      req = 4'b0001;
      req_addr[0 +: 11] = 11'h4FE;
      req_wr_data[0 +: 16] = 16'h1234;
      tick();
      check("t1_grant", 32'(grant), 32'h1);
      check("t1_if_req", 32'(if_req), 32'h1);
      check("t1_if_addr", 32'(if_addr), 32'h4FE);
      check("t1_if_wr", 32'(if_wr_data), 32'h1234);
      tick(); tick();
      check("t1_busy_req", 32'(if_req), 32'h1);
      check("t1_busy_done", 32'(done), 32'h0);
      complete(16'h5300);
      check("t1_done", 32'(done), 32'h1);
      check("t1_rd_data", 32'(rd_data), 32'h5300);
      check("t1_req_drop", 32'(if_req), 32'h0);
      check("t1_grant_held", 32'(grant), 32'h1);
      req = '0;
      tick();
      check("t1_hold_done", 32'(done), 32'h0);
      check("t1_hold_grant", 32'(grant), 32'h1);
      tick();
      check("t1_arb_grant", 32'(grant), 32'h0);

      // round robin with all four requesting, no lock
      rst_n = 1'b0; req = 4'b1111;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_req(n);
         check($sformatf("rr_gap%0d", i), 32'(n), (i == 0) ? 32'd1 : 32'd3);
         check($sformatf("rr_grant%0d", i), 32'(grant), 32'(1 << (i % 4)));
         complete(16'(i));
         check($sformatf("rr_done%0d", i), 32'(done), 32'(1 << (i % 4)));
      end
      req = '0;
      tick(); tick();

      // locked burst from requester 2, requester 0 waiting
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req = 4'b0100; lock = 4'b0100;
      req_addr[22 +: 11] = 11'h123;
      wait_req(n);
      check("b_first_grant", 32'(grant), 32'h4);
      req = 4'b0101;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            wait_req(n);
            check($sformatf("b_gap%0d", i), 32'(n), 32'd2);
         end
         check($sformatf("b_grant%0d", i), 32'(grant), 32'h4);
         complete(16'hB000 + 16'(i));
         check($sformatf("b_done%0d", i), 32'(done), 32'h4);
      end
      wait_req(n);
      check("b_rot_gap", 32'(n), 32'd3);
      check("b_rot_grant", 32'(grant), 32'h1);
      check("b_rot_addr", 32'(if_addr), 32'h4FE);
      complete(16'h0001);
      check("b_rot_done", 32'(done), 32'h1);
      wait_req(n);
      check("b_back_gap", 32'(n), 32'd3);
      check("b_back_grant", 32'(grant), 32'h4);
      check("b_back_addr", 32'(if_addr), 32'h123);

      // reset while BUSY, then pending request from requester 1
      rst_n = 1'b0; req = 4'b0010; lock = '0;
      tick();
      check("r_grant", 32'(grant), 32'h0);
      check("r_done", 32'(done), 32'h0);
      check("r_if_req", 32'(if_req), 32'h0);
      check("r_rd_data", 32'(rd_data), 32'h0);
      rst_n = 1'b1;
      tick();
      check("r_grant1", 32'(grant), 32'h2);
      check("r_if_req1", 32'(if_req), 32'h1);
      complete(16'hA5A5);
      check("r_done1", 32'(done), 32'h2);
      req = '0;
      tick(); tick();

      // spurious completion pulses while idle
      if_rd_data = 16'h0BAD;
      if_op_state = 1'b1;
      tick(); tick();
      if_op_state = 1'b0;
      check("s_done", 32'(done), 32'h0);
      check("s_grant", 32'(grant), 32'h0);
      check("s_if_req", 32'(if_req), 32'h0);
      check("s_rd_data", 32'(rd_data), 32'hA5A5);
      tick();
      check("s_done2", 32'(done), 32'h0);

`ifdef W5300_ARB_TIMEOUT_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req = 4'b0001;
      tick();
      for (int i = 0; i < 9; i++) tick();
      check("to_busy_req", 32'(if_req), 32'h1);
      check("to_busy_err", 32'(err), 32'h0);
      tick();
      check("to_if_req", 32'(if_req), 32'h0);
      check("to_err", 32'(err), 32'h1);
      check("to_done", 32'(done), 32'h1);
      check("to_rd_data", 32'(rd_data), 32'hFFFF);
      wait_req(n);
      check("to_next_gap", 32'(n), 32'd3);
      complete(16'h0042);
      check("to_next_done", 32'(done), 32'h1);
      check("to_next_rd", 32'(rd_data), 32'h0042);
      check("to_err_sticky", 32'(err), 32'h1);
      req = '0;
      tick(); tick();
`else
      check("err_tied", 32'(err), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
